// File: rtl/la_scanctrl.sv
// rtl/la_scanctrl.sv - scan chain sequencer: shift/capture/unload between a bit-serial host and the chain
// Chain state only advances when chain_ce=1, so host stalls freeze the chain in place.
module la_scanctrl #(
  parameter int LEN    = 16,
  parameter bit SI_INV = 1'b0,
  parameter bit SO_INV = 1'b0,
  parameter     PROP   = "DEFAULT"
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  input  logic [15:0] npat,
  input  logic [3:0]  ncap,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  input  logic        tx_valid,
  input  logic        tx_bit,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic        rx_bit,
  input  logic        rx_ready,
  output logic        chain_se,
  output logic        chain_si,
  input  logic        chain_so,
  output logic        chain_ce
);

  localparam int SW = $clog2(LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CAPTURE} state_t;

  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_shift_cnt, w_shift_cnt_nxt;
  logic [15:0]   r_pat_cnt, w_pat_cnt_nxt;
  logic [15:0]   r_npat, w_npat_nxt;
  logic [3:0]    r_ncap, w_ncap_nxt;
  logic [3:0]    r_cap_cnt, w_cap_cnt_nxt;
  logic          r_first, w_first_nxt;
  logic          r_final, w_final_nxt;
  logic          r_done, w_done_nxt;
  logic          w_rx_on, w_tx_ok, w_rx_ok;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= S_IDLE;
      r_shift_cnt <= '0;
      r_pat_cnt   <= '0;
      r_npat      <= '0;
      r_ncap      <= '0;
      r_cap_cnt   <= '0;
      r_first     <= 1'b0;
      r_final     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift_cnt <= w_shift_cnt_nxt;
      r_pat_cnt   <= w_pat_cnt_nxt;
      r_npat      <= w_npat_nxt;
      r_ncap      <= w_ncap_nxt;
      r_cap_cnt   <= w_cap_cnt_nxt;
      r_first     <= w_first_nxt;
      r_final     <= w_final_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // The final unload always emits, even for an unload-only run where no pattern was shifted in.
  assign w_rx_on = !r_first || r_final;
  assign w_tx_ok = r_final || tx_valid;
  assign w_rx_ok = !w_rx_on || rx_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_cnt_nxt = r_shift_cnt;
    w_pat_cnt_nxt   = r_pat_cnt;
    w_npat_nxt      = r_npat;
    w_ncap_nxt      = r_ncap;
    w_cap_cnt_nxt   = r_cap_cnt;
    w_first_nxt     = r_first;
    w_final_nxt     = r_final;
    w_done_nxt      = 1'b0;
    chain_se        = 1'b0;
    chain_ce        = 1'b0;
    chain_si        = 1'b0;
    rx_bit          = 1'b0;
    tx_ready        = 1'b0;
    rx_valid        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_npat_nxt      = npat;
          w_ncap_nxt      = (ncap == 4'd0) ? 4'd1 : ncap;
          w_first_nxt     = 1'b1;
          w_final_nxt     = (npat == 16'd0);
          w_shift_cnt_nxt = '0;
          w_pat_cnt_nxt   = '0;
          w_cap_cnt_nxt   = '0;
          w_state_nxt     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        chain_se = 1'b1;
        chain_si = r_final ? 1'b0 : (tx_bit ^ SI_INV);
        rx_bit   = chain_so ^ SO_INV;
        tx_ready = !r_final && w_rx_ok;
        rx_valid = w_rx_on && w_tx_ok;
        if (w_tx_ok && w_rx_ok) begin
          chain_ce = 1'b1;
          if (r_shift_cnt == SW'(LEN - 1)) begin
            w_shift_cnt_nxt = '0;
            if (r_final) begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_CAPTURE;
            end
          end else begin
            w_shift_cnt_nxt = r_shift_cnt + 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        chain_ce = 1'b1;
        if (r_cap_cnt == r_ncap - 4'd1) begin
          w_cap_cnt_nxt = '0;
          w_pat_cnt_nxt = r_pat_cnt + 16'd1;
          w_first_nxt   = 1'b0;
          w_final_nxt   = (r_pat_cnt + 16'd1 == r_npat);
          w_state_nxt   = S_SHIFT;
        end else begin
          w_cap_cnt_nxt = r_cap_cnt + 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort cancels any step or handshake offered this cycle.
    if (abort) begin
      w_state_nxt     = S_IDLE;
      w_shift_cnt_nxt = '0;
      w_pat_cnt_nxt   = '0;
      w_cap_cnt_nxt   = '0;
      w_done_nxt      = 1'b0;
      chain_ce        = 1'b0;
      tx_ready        = 1'b0;
      rx_valid        = 1'b0;
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;

endmodule

// File: tb/tb_la_scanctrl.sv
// tb/tb_la_scanctrl.sv - scoreboard bench for la_scanctrl with a behavioural inverting-tail scan chain
module tb_la_scanctrl;
  localparam int LEN = 4;

  logic        clk = 1'b0, nreset = 1'b0, start = 1'b0, abort = 1'b0;
  logic [15:0] npat = '0;
  logic [3:0]  ncap = '0;
  logic        tx_valid = 1'b0, tx_bit = 1'b0, rx_ready = 1'b0;
  logic        busy, done, tx_ready, rx_valid, rx_bit, chain_se, chain_si, chain_so, chain_ce;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int tx_cnt = 0, rx_cnt = 0, done_cnt = 0;
  bit rand_mode = 1'b0, unload_only = 1'b0;
  bit txq[$];
  bit expq[$];
  logic [LEN-1:0] chain, known_chain;

  la_scanctrl #(.LEN(LEN), .SI_INV(1'b0), .SO_INV(1'b1), .PROP("DEFAULT")) dut (
    .clk(clk), .nreset(nreset), .start(start), .npat(npat), .ncap(ncap), .abort(abort),
    .busy(busy), .done(done), .tx_valid(tx_valid), .tx_bit(tx_bit), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_bit(rx_bit), .rx_ready(rx_ready), .chain_se(chain_se),
    .chain_si(chain_si), .chain_so(chain_so), .chain_ce(chain_ce)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Functional capture logic of the chain's surrounding circuit.
  function automatic logic [LEN-1:0] cap_f(input logic [LEN-1:0] v);
    return {v[LEN-2:0], v[LEN-1]} ^ 4'hA;
  endfunction

  // Chain environment: cell 0 at si; tail cell has an inverting output.
  always @(posedge clk) if (chain_ce) begin
    if (chain_se) chain <= {chain[LEN-2:0], chain_si};
    else          chain <= cap_f(chain);
  end
  assign chain_so = ~chain[LEN-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Host driver: pops a tx bit when a handshake was seen before the edge.
  always begin
    bit fire;
    @(negedge clk);
    fire = nreset && tx_valid && tx_ready;
    @(posedge clk);
    #1;
    if (fire) begin
      tx_cnt++;
      if (txq.size() > 0) void'(txq.pop_front());
    end
    tx_valid = (txq.size() > 0) && (rand_mode ? ($urandom_range(1, 0) == 1) : 1'b1);
    tx_bit   = (txq.size() > 0) ? txq[0] : 1'b0;
    rx_ready = rand_mode ? ($urandom_range(1, 0) == 1) : 1'b1;
  end

  // Monitor / scoreboard.
  always @(negedge clk) if (nreset) begin
    if (chain_se) chk("ce_joint", chain_ce, (tx_ready && tx_valid) || (rx_valid && rx_ready));
    if (chain_se && unload_only) begin
      chk("unload_si", chain_si, 0);
      chk("unload_txready", tx_ready, 0);
    end
    if (rx_valid && rx_ready) begin
      rx_cnt++;
      if (expq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rx_extra: got bit %0d expected none", rx_bit);
      end else begin
        bit e;
        e = expq.pop_front();
        chk("rx_bit", rx_bit, e);
      end
    end
    if (done) done_cnt++;
  end

  task automatic run(input int np, input int nc, input bit fixed_tx, input logic [LEN-1:0] fixed_v,
                     input int exp_lat, input bit poke);
    int nce, tx0, rx0, d0, exp_rx, st, lat;
    bit got, b;
    logic [LEN-1:0] v, r;
    nce = (nc == 0) ? 1 : nc;
    tx0 = tx_cnt; rx0 = rx_cnt; d0 = done_cnt; lat = 0;
    if (np == 0) begin
      for (int j = 0; j < LEN; j++) expq.push_back(known_chain[LEN-1-j]);
      exp_rx = LEN;
    end else begin
      for (int k = 0; k < np; k++) begin
        for (int j = 0; j < LEN; j++) begin
          b = fixed_tx ? fixed_v[LEN-1-j] : 1'($urandom);
          txq.push_back(b);
          v[LEN-1-j] = b;
        end
        r = v;
        for (int c = 0; c < nce; c++) r = cap_f(r);
        for (int j = 0; j < LEN; j++) expq.push_back(r[LEN-1-j]);
      end
      exp_rx = np * LEN;
    end
    unload_only = (np == 0);
    @(posedge clk); #1;
    start = 1'b1; npat = 16'(np); ncap = 4'(nc); st = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (poke && i == 5) begin start = 1'b1; npat = 16'd7; end
      if (poke && i == 6) start = 1'b0;
      if (done) begin got = 1'b1; lat = cyc - st + 1; break; end
    end
    start = 1'b0;
    chk("done_seen", got, 1);
    if (exp_lat > 0) chk("done_latency", lat, exp_lat);
    repeat (2) @(negedge clk);
    chk("tx_count", tx_cnt - tx0, np * LEN);
    chk("rx_count", rx_cnt - rx0, exp_rx);
    chk("exp_drained", expq.size(), 0);
    chk("done_once", done_cnt - d0, 1);
    chk("idle_after", busy, 0);
    unload_only = 1'b0;
    known_chain = '0;
    expq.delete();
    txq.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int steps, d0;
    chain = 4'($urandom);
    known_chain = chain;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_se", chain_se, 0);
    chk("rst_ce", chain_ce, 0);
    chk("rst_txready", tx_ready, 0);
    chk("rst_rxvalid", rx_valid, 0);
    @(posedge clk); #1 nreset = 1'b1;

    run(0, 1, 1'b0, '0, 0, 1'b0);
    run(1, 1, 1'b1, 4'b1011, 11, 1'b0);
    run(2, 3, 1'b0, '0, 0, 1'b0);
    run(0, 0, 1'b0, '0, 0, 1'b0);

    rand_mode = 1'b1;
    for (int t = 0; t < 6; t++) run($urandom_range(4, 1), $urandom_range(15, 0), 1'b0, '0, 0, t == 2);
    rand_mode = 1'b0;

    // Abort while shifting the first pattern in, after two steps.
    for (int j = 0; j < LEN; j++) txq.push_back(1'($urandom));
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1; npat = 16'd1; ncap = 4'd1;
    @(posedge clk); #1 start = 1'b0;
    steps = 0;
    for (int i = 0; i < 50 && steps < 2; i++) begin
      @(negedge clk);
      if (chain_se && chain_ce) steps++;
    end
    chk("abort_reached_step2", steps, 2);
    @(posedge clk); #1 abort = 1'b1;
    @(negedge clk);
    chk("abort_ce", chain_ce, 0);
    chk("abort_txready", tx_ready, 0);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", busy, 0);
    txq.delete();
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    run(1, 2, 1'b0, '0, 0, 1'b0);

    // Reset in the middle of a long capture.
    for (int j = 0; j < LEN; j++) txq.push_back(1'($urandom));
    @(posedge clk); #1 start = 1'b1; npat = 16'd1; ncap = 4'd8;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy && !chain_se) break;
    end
    chk("reached_capture", busy && !chain_se, 1);
    #1 nreset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ce", chain_ce, 0);
    chk("mid_rst_se", chain_se, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rxvalid", rx_valid, 0);
    txq.delete();
    @(posedge clk); #1 nreset = 1'b1;
    run(2, 1, 1'b0, '0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
